// File: rtl/jk_pkg.sv
// Shared JK-cell definitions: the per-cell command encoding and the helper
// that turns a (current bit, next bit) pair into a J/K drive.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_cmd_t;

    // Counting uses toggle form (J=K=T); wrap and load force the bit with set/reset form.
    function automatic jk_cmd_t jk_cmd(input logic cur, input logic nxt, input logic set_reset_form);
        if (set_reset_form)
            return nxt ? JK_SET : JK_RESET;
        else
            return (cur != nxt) ? JK_TOGGLE : JK_HOLD;
    endfunction

endpackage

// File: rtl/jk_ff.sv
// Single-bit edge-triggered JK flip-flop with asynchronous active-low reset.
module jk_ff
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else begin
            case (jk_cmd_t'({j, k}))
                JK_HOLD:   q <= q;
                JK_RESET:  q <= 1'b0;
                JK_SET:    q <= 1'b1;
                JK_TOGGLE: q <= ~q;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter stored in a bank of JK cells, with load and terminal count.
// Optional macro JK_MOD_COUNTER_SAT_EN: saturate at the limits instead of wrapping.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("jk_mod_counter: WIDTH must be in 2..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("jk_mod_counter: MODULUS must be in 2..2**WIDTH");
    end

    // One extra bit so MODULUS == 2**WIDTH is representable in range comparisons.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_Q  = '0;

    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] j_bus;
    logic [WIDTH-1:0] k_bus;
    logic             set_reset;
    logic             at_max;
    logic             at_zero;
    logic             out_of_range;

    assign at_max       = (q == MAX_Q);
    assign at_zero      = (q == ZERO_Q);
    assign out_of_range = ({1'b0, q} >= MOD_EXT);
    assign tc           = en & ~load & ((up & at_max) | (~up & at_zero));

    always_comb begin
        next_q    = q;
        set_reset = 1'b0;
        if (load) begin
            set_reset = 1'b1;
            next_q    = ({1'b0, d} >= MOD_EXT) ? MAX_Q : d;
        end else if (en) begin
            if (out_of_range) begin
                set_reset = 1'b1;
                next_q    = ZERO_Q;
            end else if (up) begin
                if (at_max) begin
`ifdef JK_MOD_COUNTER_SAT_EN
                    next_q    = MAX_Q;
`else
                    set_reset = 1'b1;
                    next_q    = ZERO_Q;
`endif
                end else begin
                    next_q = q + 1'b1;
                end
            end else begin
                if (at_zero) begin
`ifdef JK_MOD_COUNTER_SAT_EN
                    next_q    = ZERO_Q;
`else
                    set_reset = 1'b1;
                    next_q    = MAX_Q;
`endif
                end else begin
                    next_q = q - 1'b1;
                end
            end
        end
    end

    // A saturated limit leaves next_q == q in toggle form, so every cell sees J=K=0.
    always_comb begin
        j_bus = '0;
        k_bus = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j_bus[i], k_bus[i]} = jk_cmd(q[i], next_q[i], set_reset);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_ff u_jk_ff (
            .clk (clk),
            .rst (rst),
            .j   (j_bus[i]),
            .k   (k_bus[i]),
            .q   (q[i])
        );
    end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Table-driven scoreboard bench for jk_mod_counter (default WIDTH=4, MODULUS=10),
// with a hand-written asynchronous reset sequence and saturating-mode vectors.
module tb_jk_mod_counter;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;
`ifdef JK_MOD_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;

    typedef struct {
        string            name;
        logic             ld;
        logic             en;
        logic             up;
        logic [WIDTH-1:0] d;
        logic             exp_tc;
        logic [WIDTH-1:0] exp_q;
    } vec_t;

    vec_t             vecs[$];
    logic [WIDTH-1:0] exp_queue[$];
    int               n_checks = 0;
    int               n_pass   = 0;

    always #5 clk = ~clk;

    jk_mod_counter #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .up   (up),
        .load (load),
        .d    (d),
        .q    (q),
        .tc   (tc)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected)
            n_pass++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic void addVec(input string name, input logic ld, input logic e, input logic u,
                                   input int dv, input logic etc, input int eq);
        vec_t v;
        v.name   = name;
        v.ld     = ld;
        v.en     = e;
        v.up     = u;
        v.d      = WIDTH'(dv);
        v.exp_tc = etc;
        v.exp_q  = WIDTH'(eq);
        vecs.push_back(v);
    endfunction

    // Drive one vector just after an edge, check tc before the next edge, then q after it.
    task automatic applyStimulus(input vec_t v);
        logic [WIDTH-1:0] expq;
        load = v.ld;
        en   = v.en;
        up   = v.up;
        d    = v.d;
        #1;
        checkOutput({v.name, " tc"}, int'(tc), int'(v.exp_tc));
        exp_queue.push_back(v.exp_q);
        @(posedge clk);
        #1;
        if (exp_queue.size() == 0) begin
            checkOutput({v.name, " scoreboard empty"}, 1, 0);
        end else begin
            expq = exp_queue.pop_front();
            checkOutput({v.name, " q"}, int'(q), int'(expq));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Up wrap from 0: tc only while q is at the top.
        for (int k = 0; k < MODULUS; k++)
            addVec("up_wrap", 1'b0, 1'b1, 1'b1, 0, (k == MODULUS - 1),
                   (k == MODULUS - 1) ? (SAT ? MODULUS - 1 : 0) : k + 1);
        addVec("load2",      1'b1, 1'b0, 1'b0,  2, 1'b0, 2);
        addVec("down_2",     1'b0, 1'b1, 1'b0,  0, 1'b0, 1);
        addVec("down_1",     1'b0, 1'b1, 1'b0,  0, 1'b0, 0);
        addVec("down_wrap",  1'b0, 1'b1, 1'b0,  0, 1'b1, SAT ? 0 : 9);
        addVec("load9",      1'b1, 1'b0, 1'b0,  9, 1'b0, 9);
        addVec("down_9",     1'b0, 1'b1, 1'b0,  0, 1'b0, 8);
        addVec("load_prio",  1'b1, 1'b1, 1'b1,  5, 1'b0, 5);
        addVec("clamp12",    1'b1, 1'b0, 1'b0, 12, 1'b0, 9);
        addVec("clamp15_tc", 1'b1, 1'b1, 1'b1, 15, 1'b0, 9);
        addVec("load0",      1'b1, 1'b0, 1'b1,  0, 1'b0, 0);
        addVec("hold_zero",  1'b0, 1'b0, 1'b0,  0, 1'b0, 0);
        addVec("load4",      1'b1, 1'b0, 1'b0,  4, 1'b0, 4);
        for (int k = 0; k < 3; k++)
            addVec("hold4", 1'b0, 1'b0, 1'b1, 0, 1'b0, 4);
        addVec("flip_up",    1'b0, 1'b1, 1'b1,  0, 1'b0, 5);
        addVec("flip_dn",    1'b0, 1'b1, 1'b0,  0, 1'b0, 4);
        addVec("flip_up2",   1'b0, 1'b1, 1'b1,  0, 1'b0, 5);
        addVec("flip_dn2",   1'b0, 1'b1, 1'b0,  0, 1'b0, 4);
`ifdef JK_MOD_COUNTER_SAT_EN
        addVec("sat_load8",  1'b1, 1'b0, 1'b1,  8, 1'b0, 8);
        addVec("sat_up8",    1'b0, 1'b1, 1'b1,  0, 1'b0, 9);
        for (int k = 0; k < 3; k++)
            addVec("sat_up9", 1'b0, 1'b1, 1'b1, 0, 1'b1, 9);
        addVec("sat_load1",  1'b1, 1'b0, 1'b0,  1, 1'b0, 1);
        addVec("sat_dn1",    1'b0, 1'b1, 1'b0,  0, 1'b0, 0);
        addVec("sat_dn0",    1'b0, 1'b1, 1'b0,  0, 1'b1, 0);
`endif

        rst  = 1'b0;
        en   = 1'b0;
        up   = 1'b1;
        load = 1'b0;
        d    = '0;
        #1;
        checkOutput("reset q", int'(q), 0);
        checkOutput("reset tc", int'(tc), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        foreach (vecs[i])
            applyStimulus(vecs[i]);

        // Asynchronous reset mid-count, between edges.
        applyStimulus('{"load7", 1'b1, 1'b0, 1'b1, WIDTH'(7), 1'b0, WIDTH'(7)});
        load = 1'b0;
        en   = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset q", int'(q), 0);
        checkOutput("async_reset tc", int'(tc), 0);
        en = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_held q", int'(q), 0);
        rst = 1'b1;
        applyStimulus('{"post_release", 1'b0, 1'b1, 1'b1, WIDTH'(0), 1'b0, WIDTH'(1)});

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
